// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the LEGv8 execute stage (ALU control, branch/PC-select codes,
// R-type opcodes, condition codes). Shift opcodes are decoded only when EX_SHIFT_EN is defined.
package ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_EOR,
        ALU_PASSB,
        ALU_ONE,
        ALU_LSL,
        ALU_LSR
    } alu_ctrl_e;

    localparam logic [2:0] BR_NONE   = 3'd0;
    localparam logic [2:0] BR_ZERO   = 3'd1;
    localparam logic [2:0] BR_NZERO  = 3'd2;
    localparam logic [2:0] BR_BRANCH = 3'd3;
    localparam logic [2:0] BR_COND   = 3'd4;
    localparam logic [2:0] BR_REG    = 3'd5;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_REG    = 2'd2;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    localparam logic [4:0] CC_EQ = 5'd0,  CC_NE = 5'd1,  CC_HS = 5'd2,  CC_LO = 5'd3;
    localparam logic [4:0] CC_MI = 5'd4,  CC_PL = 5'd5,  CC_VS = 5'd6,  CC_VC = 5'd7;
    localparam logic [4:0] CC_HI = 5'd8,  CC_LS = 5'd9,  CC_GE = 5'd10, CC_LT = 5'd11;
    localparam logic [4:0] CC_GT = 5'd12, CC_LE = 5'd13, CC_AL = 5'd14, CC_NV = 5'd15;

    // nzvc is packed {N, Z, V, C}; codes above 15 never hold.
    function automatic logic cond_holds(input logic [4:0] cond, input logic [3:0] nzvc);
        logic n, z, v, c;
        {n, z, v, c} = nzvc;
        case (cond)
            CC_EQ:        return z;
            CC_NE:        return !z;
            CC_HS:        return c;
            CC_LO:        return !c;
            CC_MI:        return n;
            CC_PL:        return !n;
            CC_VS:        return v;
            CC_VC:        return !v;
            CC_HI:        return c && !z;
            CC_LS:        return !(c && !z);
            CC_GE:        return n == v;
            CC_LT:        return n != v;
            CC_GT:        return !z && (n == v);
            CC_LE:        return !(!z && (n == v));
            CC_AL, CC_NV: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_alu_ctrl.sv
// ALU control decode: ALUOp plus R-type opcode to an ALU operation.
// LSL/LSR are recognised only when EX_SHIFT_EN is defined; otherwise they decode as ADD.
module ex_alu_ctrl
    import ex_stage_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output alu_ctrl_e   ctrl
);

    always_comb begin
        // NOTE: default assigned first so every path drives ctrl and no latch is inferred.
        ctrl = ALU_ADD;
        case (alu_op)
            2'b00: ctrl = ALU_ADD;
            2'b01: ctrl = ALU_PASSB;
            2'b11: ctrl = ALU_ONE;
            default: begin
                case (opcode)
                    OP_ADD, OP_ADDS: ctrl = ALU_ADD;
                    OP_SUB, OP_SUBS: ctrl = ALU_SUB;
                    OP_AND, OP_ANDS: ctrl = ALU_AND;
                    OP_ORR:          ctrl = ALU_ORR;
                    OP_EOR:          ctrl = ALU_EOR;
`ifdef EX_SHIFT_EN
                    OP_LSL:          ctrl = ALU_LSL;
                    OP_LSR:          ctrl = ALU_LSR;
`endif
                    default:         ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// LEGv8 execute stage: 64-bit ALU, branch-target adder, NZVC flag register and PC-source select.
// Define EX_SHIFT_EN to add LSL/LSR (shift amount from inst[15:10]) to the R-type decode.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD-1:0]      r_data1,
    input  logic [WORD-1:0]      r_data2,
    input  logic [WORD-1:0]      ex_data,
    input  logic [INST_SIZE-1:0] inst,
    input  logic [1:0]           ALUOp,
    input  logic                 ALUSrc,
    input  logic [2:0]           BranchOp,
    input  logic                 SregUp,
    input  logic [WORD-1:0]      pc,
    output logic [WORD-1:0]      ALUOut,
    output logic [1:0]           PCSrc,
    output logic [WORD-1:0]      ALU_res
);

    alu_ctrl_e       ctrl;
    logic [WORD-1:0] a, b;
    logic [WORD:0]   sum;
    logic            carry, ovf, neg, zero;
    logic [3:0]      nzvc;
    logic [5:0]      shamt;
    logic            unused_inst;

    assign a     = r_data1;
    assign b     = ALUSrc ? ex_data : r_data2;
    assign shamt = inst[15:10];
    assign unused_inst = ^{inst[20:16], inst[9:5], shamt};

    ex_alu_ctrl u_alu_ctrl (
        .alu_op (ALUOp),
        .opcode (inst[31:21]),
        .ctrl   (ctrl)
    );

    always_comb begin
        sum    = '0;
        ALUOut = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                ALUOut = sum[WORD-1:0];
                carry  = sum[WORD];
                ovf    = (a[WORD-1] == b[WORD-1]) && (ALUOut[WORD-1] != a[WORD-1]);
            end
            ALU_SUB: begin
                // a + ~b + 1 carries out exactly when a >= b unsigned.
                sum    = {1'b0, a} + {1'b0, ~b} + {{WORD{1'b0}}, 1'b1};
                ALUOut = sum[WORD-1:0];
                carry  = sum[WORD];
                ovf    = (a[WORD-1] != b[WORD-1]) && (ALUOut[WORD-1] != a[WORD-1]);
            end
            ALU_AND:   ALUOut = a & b;
            ALU_ORR:   ALUOut = a | b;
            ALU_EOR:   ALUOut = a ^ b;
            ALU_PASSB: ALUOut = b;
            ALU_ONE:   ALUOut = {{(WORD-1){1'b0}}, 1'b1};
`ifdef EX_SHIFT_EN
            ALU_LSL:   ALUOut = a << shamt;
            ALU_LSR:   ALUOut = a >> shamt;
`endif
            default:   ALUOut = '0;
        endcase
    end

    assign neg  = ALUOut[WORD-1];
    assign zero = (ALUOut == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so any reader in the same edge sees the pre-edge flags.
        if (!rst_n)
            nzvc <= 4'b0000;
        else if (SregUp)
            nzvc <= {neg, zero, ovf, carry};
    end

    assign ALU_res = pc + (ex_data << 2);

    always_comb begin
        PCSrc = PC_SEQ;
        case (BranchOp)
            BR_ZERO:   PCSrc = zero ? PC_TARGET : PC_SEQ;
            BR_NZERO:  PCSrc = zero ? PC_SEQ : PC_TARGET;
            BR_BRANCH: PCSrc = PC_TARGET;
            BR_COND:   PCSrc = cond_holds(inst[4:0], nzvc) ? PC_TARGET : PC_SEQ;
            BR_REG:    PCSrc = PC_REG;
            default:   PCSrc = PC_SEQ;
        endcase
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expectations for LSL/LSR follow EX_SHIFT_EN.
module tb_ex_stage;

    localparam int WORD      = 64;
    localparam int INST_SIZE = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [WORD-1:0]      r_data1, r_data2, ex_data, pc;
    logic [INST_SIZE-1:0] inst;
    logic [1:0]           ALUOp;
    logic                 ALUSrc, SregUp;
    logic [2:0]           BranchOp;
    logic [WORD-1:0]      ALUOut, ALU_res;
    logic [1:0]           PCSrc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage #(.WORD(WORD), .INST_SIZE(INST_SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r_data1  (r_data1),
        .r_data2  (r_data2),
        .ex_data  (ex_data),
        .inst     (inst),
        .ALUOp    (ALUOp),
        .ALUSrc   (ALUSrc),
        .BranchOp (BranchOp),
        .SregUp   (SregUp),
        .pc       (pc),
        .ALUOut   (ALUOut),
        .PCSrc    (PCSrc),
        .ALU_res  (ALU_res)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] ex;
        logic [63:0] out;
        logic [63:0] res;
    } mem_vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] out;
    } rtype_vec_t;

    typedef struct {
        logic [63:0] ex;
        logic [1:0]  op;
        logic [2:0]  bop;
        logic [63:0] p;
        logic [63:0] out;
        logic [1:0]  src;
        logic [63:0] res;
    } br_vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] a;
        logic [63:0] b;
        logic        up;
        logic [15:0] mask;
    } flag_vec_t;

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] ex,
                         input logic [31:0] ins, input logic [1:0] op, input logic src,
                         input logic [2:0] bop, input logic up, input logic [63:0] p);
        r_data1  = a;
        r_data2  = b;
        ex_data  = ex;
        inst     = ins;
        ALUOp    = op;
        ALUSrc   = src;
        BranchOp = bop;
        SregUp   = up;
        pc       = p;
    endtask

    // Flags cleared by reset: sweep every 5-bit condition code, including the out-of-range ones.
    task automatic test_reset();
        logic [31:0] mask;
        mask  = 32'h0000_D6AA;
        rst_n = 1'b0;
        drive(64'd5, 64'd5, 64'd0, {11'b11101011000, 21'd0}, 2'b10, 1'b0, 3'd0, 1'b1, 64'd200);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            drive(64'd0, 64'd0, 64'd0, {27'd0, 5'(c)}, 2'b00, 1'b0, 3'd4, 1'b0, 64'd200);
            #1;
            checks++;
            if (PCSrc !== (mask[c] ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL reset_cond[%0d] PCSrc got %0d want %0d", c, PCSrc, mask[c]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mem();
        mem_vec_t v[2];
        v[0] = '{a: 64'd22, ex: 64'd64, out: 64'd86,  res: 64'd456};
        v[1] = '{a: 64'd22, ex: 64'd96, out: 64'd118, res: 64'd584};
        foreach (v[i]) begin
            @(negedge clk);
            drive(v[i].a, 64'd7, v[i].ex, 32'd0, 2'b00, 1'b1, 3'd0, 1'b0, 64'd200);
            #1;
            checks++;
            if (ALUOut !== v[i].out) begin
                errors++;
                $display("FAIL mem[%0d] ALUOut got %h want %h", i, ALUOut, v[i].out);
            end
            checks++;
            if (ALU_res !== v[i].res) begin
                errors++;
                $display("FAIL mem[%0d] ALU_res got %h want %h", i, ALU_res, v[i].res);
            end
            checks++;
            if (PCSrc !== 2'd0) begin
                errors++;
                $display("FAIL mem[%0d] PCSrc got %0d want 0", i, PCSrc);
            end
        end
    endtask

    task automatic test_rtype();
        rtype_vec_t v[11];
        logic [63:0] lsl_exp, lsr_exp;
`ifdef EX_SHIFT_EN
        lsl_exp = 64'd48;
        lsr_exp = 64'h8;
`else
        lsl_exp = 64'd8;
        lsr_exp = 64'h85;
`endif
        // ADD vector with ex_data equal to the instruction word; checks target adder too.
        @(negedge clk);
        drive(64'd19, 64'd9, 64'h8B09026A, 32'h8B09026A, 2'b10, 1'b0, 3'd0, 1'b0, 64'd200);
        #1;
        checks++;
        if (ALUOut !== 64'd28) begin
            errors++;
            $display("FAIL add ALUOut got %h want %h", ALUOut, 64'd28);
        end
        checks++;
        if (ALU_res !== 64'h2_2C24_0A70) begin
            errors++;
            $display("FAIL add ALU_res got %h want %h", ALU_res, 64'h2_2C24_0A70);
        end

        v[0]  = '{ins: 32'hCB0A028B,                        a: 64'd20,    b: 64'd20,    out: 64'd0};
        v[1]  = '{ins: {11'b10101011000, 21'd0},            a: 64'd7,     b: 64'd5,     out: 64'd12};
        v[2]  = '{ins: {11'b11101011000, 21'd0},            a: 64'd3,     b: 64'd5,     out: 64'hFFFF_FFFF_FFFF_FFFE};
        v[3]  = '{ins: {11'b10001010000, 21'd0},            a: 64'hF0F0,  b: 64'hFF00,  out: 64'hF000};
        v[4]  = '{ins: {11'b11101010000, 21'd0},            a: 64'hF0F0,  b: 64'hFF00,  out: 64'hF000};
        v[5]  = '{ins: {11'b10101010000, 21'd0},            a: 64'hF0F0,  b: 64'hFF00,  out: 64'hFFF0};
        v[6]  = '{ins: {11'b11001010000, 21'd0},            a: 64'hF0F0,  b: 64'hFF00,  out: 64'h0FF0};
        v[7]  = '{ins: {11'b11111111111, 21'd0},            a: 64'd7,     b: 64'd5,     out: 64'd12};
        v[8]  = '{ins: {11'b11010011011, 5'd0, 6'd4, 10'd0}, a: 64'd3,     b: 64'd5,     out: lsl_exp};
        v[9]  = '{ins: {11'b11010011010, 5'd0, 6'd4, 10'd0}, a: 64'h80,    b: 64'd5,     out: lsr_exp};
        v[10] = '{ins: {11'b10001011000, 21'd0},            a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, out: 64'd1};
        foreach (v[i]) begin
            @(negedge clk);
            drive(v[i].a, v[i].b, 64'hDEAD, v[i].ins, 2'b10, 1'b0, 3'd0, 1'b0, 64'd200);
            #1;
            checks++;
            if (ALUOut !== v[i].out) begin
                errors++;
                $display("FAIL rtype[%0d] ALUOut got %h want %h", i, ALUOut, v[i].out);
            end
        end

        // ALUSrc selects ex_data over r_data2.
        @(negedge clk);
        drive(64'd19, 64'd9, 64'd100, 32'h8B09026A, 2'b10, 1'b1, 3'd0, 1'b0, 64'd200);
        #1;
        checks++;
        if (ALUOut !== 64'd119) begin
            errors++;
            $display("FAIL alusrc ALUOut got %h want %h", ALUOut, 64'd119);
        end
    endtask

    task automatic test_branch();
        br_vec_t v[10];
        v[0] = '{ex: 64'hFFFF_FFFF_FFFF_FFFB, op: 2'b01, bop: 3'd1, p: 64'd200,
                 out: 64'hFFFF_FFFF_FFFF_FFFB, src: 2'd0, res: 64'd180};
        v[1] = '{ex: 64'd8,  op: 2'b01, bop: 3'd2, p: 64'd200, out: 64'd8,  src: 2'd1, res: 64'hE8};
        v[2] = '{ex: 64'd0,  op: 2'b01, bop: 3'd1, p: 64'd200, out: 64'd0,  src: 2'd1, res: 64'd200};
        v[3] = '{ex: 64'd0,  op: 2'b01, bop: 3'd2, p: 64'd200, out: 64'd0,  src: 2'd0, res: 64'd200};
        v[4] = '{ex: 64'd64, op: 2'b11, bop: 3'd3, p: 64'd200, out: 64'd1,  src: 2'd1, res: 64'd456};
        v[5] = '{ex: 64'd64, op: 2'b11, bop: 3'd5, p: 64'd200, out: 64'd1,  src: 2'd2, res: 64'd456};
        v[6] = '{ex: 64'd64, op: 2'b11, bop: 3'd6, p: 64'd200, out: 64'd1,  src: 2'd0, res: 64'd456};
        v[7] = '{ex: 64'd64, op: 2'b11, bop: 3'd7, p: 64'd200, out: 64'd1,  src: 2'd0, res: 64'd456};
        v[8] = '{ex: 64'd64, op: 2'b11, bop: 3'd0, p: 64'd200, out: 64'd1,  src: 2'd0, res: 64'd456};
        v[9] = '{ex: 64'd8,  op: 2'b01, bop: 3'd0, p: 64'hFFFF_FFFF_FFFF_FFF0,
                 out: 64'd8, src: 2'd0, res: 64'h10};
        foreach (v[i]) begin
            @(negedge clk);
            drive(64'h1000, 64'd3, v[i].ex, 32'd0, v[i].op, 1'b1, v[i].bop, 1'b0, v[i].p);
            #1;
            checks++;
            if (ALUOut !== v[i].out) begin
                errors++;
                $display("FAIL branch[%0d] ALUOut got %h want %h", i, ALUOut, v[i].out);
            end
            checks++;
            if (PCSrc !== v[i].src) begin
                errors++;
                $display("FAIL branch[%0d] PCSrc got %0d want %0d", i, PCSrc, v[i].src);
            end
            checks++;
            if (ALU_res !== v[i].res) begin
                errors++;
                $display("FAIL branch[%0d] ALU_res got %h want %h", i, ALU_res, v[i].res);
            end
        end
    endtask

    // Load flags from a sequence of flag-setting ops (one held with SregUp=0), sweeping B.cond after each.
    task automatic test_flags_cond();
        flag_vec_t v[6];
        v[0] = '{ins: {11'b11101011000, 21'd0}, a: 64'd5, b: 64'd5, up: 1'b1, mask: 16'hE6A5};
        v[1] = '{ins: {11'b11101011000, 21'd0}, a: 64'd5, b: 64'd3, up: 1'b1, mask: 16'hD5A6};
        v[2] = '{ins: {11'b11101011000, 21'd0}, a: 64'd3, b: 64'd5, up: 1'b0, mask: 16'hD5A6};
        v[3] = '{ins: {11'b10101011000, 21'd0}, a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, up: 1'b1, mask: 16'hD65A};
        v[4] = '{ins: {11'b11101011000, 21'd0}, a: 64'd3, b: 64'd5, up: 1'b1, mask: 16'hEA9A};
        v[5] = '{ins: {11'b10101011000, 21'd0}, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, up: 1'b1, mask: 16'hE6A5};
        foreach (v[i]) begin
            @(negedge clk);
            drive(v[i].a, v[i].b, 64'd0, v[i].ins, 2'b10, 1'b0, 3'd0, v[i].up, 64'd200);
            @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                drive(64'd0, 64'd0, 64'd0, {27'd0, 5'(c)}, 2'b00, 1'b0, 3'd4, 1'b0, 64'd200);
                #1;
                checks++;
                if (PCSrc !== (v[i].mask[c] ? 2'd1 : 2'd0)) begin
                    errors++;
                    $display("FAIL flags[%0d] cond %0d PCSrc got %0d want %0d", i, c, PCSrc, v[i].mask[c]);
                end
            end
        end
    endtask

    // SregUp and B.EQ in the same cycle: the branch sees the flags from before the edge.
    task automatic test_same_edge();
        @(negedge clk);
        drive(64'd5, 64'd5, 64'd0, {11'b11101011000, 21'd0}, 2'b10, 1'b0, 3'd0, 1'b1, 64'd200);
        @(negedge clk);
        drive(64'd5, 64'd3, 64'd0, {11'b11101011000, 16'd0, 5'd0}, 2'b10, 1'b0, 3'd4, 1'b1, 64'd200);
        #1;
        checks++;
        if (PCSrc !== 2'd1) begin
            errors++;
            $display("FAIL same_edge_before PCSrc got %0d want 1", PCSrc);
        end
        @(negedge clk);
        SregUp = 1'b0;
        #1;
        checks++;
        if (PCSrc !== 2'd0) begin
            errors++;
            $display("FAIL same_edge_after PCSrc got %0d want 0", PCSrc);
        end
    endtask

    // Asynchronous reset mid-cycle clears Z, so B.EQ drops immediately.
    task automatic test_reset_midop();
        @(negedge clk);
        drive(64'd5, 64'd5, 64'd0, {11'b11101011000, 21'd0}, 2'b10, 1'b0, 3'd0, 1'b1, 64'd200);
        @(negedge clk);
        drive(64'd0, 64'd0, 64'd0, {27'd0, 5'd0}, 2'b00, 1'b0, 3'd4, 1'b0, 64'd200);
        #1;
        checks++;
        if (PCSrc !== 2'd1) begin
            errors++;
            $display("FAIL beq_before_reset PCSrc got %0d want 1", PCSrc);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (PCSrc !== 2'd0) begin
            errors++;
            $display("FAIL beq_after_reset PCSrc got %0d want 0", PCSrc);
        end
        inst = {27'd0, 5'd1};
        #1;
        checks++;
        if (PCSrc !== 2'd1) begin
            errors++;
            $display("FAIL bne_after_reset PCSrc got %0d want 1", PCSrc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mem();
        test_rtype();
        test_branch();
        test_flags_cond();
        test_same_edge();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
